// File: rtl/rv32im_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter for the rv32im core.
// Master 0 is instruction fetch, master 1 is data; grant held for a whole cyc.
module rv32im_wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [XLEN-1:2] m0_adr_i,
  input  logic [XLEN-1:0] m0_dat_i,
  input  logic [3:0]      m0_sel_i,
  output logic [XLEN-1:0] m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [XLEN-1:2] m1_adr_i,
  input  logic [XLEN-1:0] m1_dat_i,
  input  logic [3:0]      m1_sel_i,
  output logic [XLEN-1:0] m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [XLEN-1:2] s_adr_o,
  output logic [XLEN-1:0] s_dat_o,
  output logic [3:0]      s_sel_o,
  input  logic [XLEN-1:0] s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] wd_cnt;
  logic          g0;
  logic          g1;
  logic          release_g;
  logic          wd_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
          end else if (m1_cyc_i) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
          end
        end
        GRANT0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state      <= GRANT1;
              last_grant <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GRANT1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state      <= GRANT0;
              last_grant <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign g0      = (state == GRANT0);
  assign g1      = (state == GRANT1);
  assign grant_o = {g1, g0};

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (g0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (g1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // Grant only ever changes when the owner drops cyc.
  assign release_g = (g0 && !m0_cyc_i) || (g1 && !m1_cyc_i);

  assign wd_fire = (wd_cnt == CW'(TIMEOUT - 1)) && s_stb_o
                && !s_ack_i && !s_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (!s_stb_o || s_ack_i || s_err_i || wd_fire || release_g) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i && g0;
  assign m1_ack_o = s_ack_i && g1;
  assign m0_err_o = (s_err_i || wd_fire) && g0;
  assign m1_err_o = (s_err_i || wd_fire) && g1;

endmodule

// File: tb/tb_rv32im_wb_arbiter.sv
// Directed bench for rv32im_wb_arbiter (TIMEOUT=8).
// Inputs change 1ns after a rising edge; outputs are sampled mid-cycle.
module tb_rv32im_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:2] m0_adr_i;
  logic [31:0] m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:2] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:2] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  grant_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  rv32im_wb_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    idle_all();
    #2;
    total++;
    if (grant_o !== 2'b00) $display("FAIL reset_grant got %b exp 00", grant_o);
    else passed++;
    total++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 7'd0)
      $display("FAIL reset_s got %b exp 0", {s_cyc_o, s_stb_o, s_we_o, s_sel_o});
    else passed++;
    total++;
    if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'd0)
      $display("FAIL reset_ackerr got %b exp 0000",
               {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
    else passed++;
    step();
    step();
    rst_i = 0;
    step();
  endtask

  task automatic test_single_m1();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
    m1_adr_i = 30'h100; m1_dat_i = 32'hCAFE_0001; m1_sel_i = 4'hF;
    #1;
    total++;
    if (s_cyc_o !== 1'b0) $display("FAIL m1_latency got %b exp 0", s_cyc_o);
    else passed++;
    step();
    total++;
    if (grant_o !== 2'b10) $display("FAIL m1_grant got %b exp 10", grant_o);
    else passed++;
    total++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o} !== {3'b111, 30'h100})
      $display("FAIL m1_bus got %b %h exp 111 100",
               {s_cyc_o, s_stb_o, s_we_o}, s_adr_o);
    else passed++;
    total++;
    if ({s_dat_o, s_sel_o} !== {32'hCAFE_0001, 4'hF})
      $display("FAIL m1_wdata got %h %h exp cafe0001 f", s_dat_o, s_sel_o);
    else passed++;
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1;
    total++;
    if ({m1_ack_o, m0_ack_o} !== 2'b10)
      $display("FAIL m1_ack got %b exp 10", {m1_ack_o, m0_ack_o});
    else passed++;
    total++;
    if (m1_dat_o !== 32'h1234_5678)
      $display("FAIL m1_rdata got %h exp 12345678", m1_dat_o);
    else passed++;
    idle_all();
    step();
    total++;
    if (grant_o !== 2'b00) $display("FAIL m1_release got %b exp 00", grant_o);
    else passed++;
  endtask

  task automatic test_tie();
    rst_i = 1;
    #2;
    rst_i = 0;
    step();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 30'h0AA;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 30'h0BB;
    step();
    total++;
    if (grant_o !== 2'b01) $display("FAIL tie_first got %b exp 01", grant_o);
    else passed++;
    total++;
    if (s_adr_o !== 30'h0AA) $display("FAIL tie_adr0 got %h exp 0aa", s_adr_o);
    else passed++;
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    total++;
    if (grant_o !== 2'b10) $display("FAIL tie_handover got %b exp 10", grant_o);
    else passed++;
    total++;
    if (s_adr_o !== 30'h0BB) $display("FAIL tie_adr1 got %h exp 0bb", s_adr_o);
    else passed++;
    idle_all();
    step();
  endtask

  task automatic test_back_to_back();
    m0_cyc_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      m0_stb_i = 1; m0_adr_i = 30'(i + 4); s_ack_i = 1;
      #1;
      total++;
      if ({grant_o, m0_ack_o, m1_ack_o} !== 4'b0110)
        $display("FAIL b2b_%0d got %b exp 0110", i,
                 {grant_o, m0_ack_o, m1_ack_o});
      else passed++;
      step();
    end
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    step();
    total++;
    if (grant_o !== 2'b10) $display("FAIL b2b_m1 got %b exp 10", grant_o);
    else passed++;
    idle_all();
    step();
  endtask

  task automatic test_timeout();
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    for (int k = 1; k <= 10; k++) begin
      total++;
      if ({m0_err_o, m1_err_o} !== {(k == 8), 1'b0})
        $display("FAIL wd_cycle%0d got %b exp %b", k,
                 {m0_err_o, m1_err_o}, {(k == 8), 1'b0});
      else passed++;
      step();
    end
    idle_all();
    step();
  endtask

  task automatic test_async_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    s_ack_i = 1;
    #2;
    rst_i = 1;
    #1;
    total++;
    if ({s_cyc_o, grant_o, m1_ack_o, m0_ack_o} !== 5'd0)
      $display("FAIL async_rst got %b exp 0",
               {s_cyc_o, grant_o, m1_ack_o, m0_ack_o});
    else passed++;
    #1;
    rst_i = 0;
    s_ack_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    total++;
    if (grant_o !== 2'b01) $display("FAIL rst_tie got %b exp 01", grant_o);
    else passed++;
  endtask

  task automatic test_slave_err();
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    total++;
    if (grant_o !== 2'b10) $display("FAIL err_grant got %b exp 10", grant_o);
    else passed++;
    s_err_i = 1;
    #1;
    total++;
    if ({m1_err_o, m0_err_o} !== 2'b10)
      $display("FAIL err_route got %b exp 10", {m1_err_o, m0_err_o});
    else passed++;
    s_err_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    total++;
    if (grant_o !== 2'b10) $display("FAIL err_hold got %b exp 10", grant_o);
    else passed++;
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    total++;
    if (grant_o !== 2'b01) $display("FAIL err_next got %b exp 01", grant_o);
    else passed++;
    idle_all();
    step();
  endtask

  initial begin
    test_reset();
    test_single_m1();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_slave_err();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
